// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
//
// Word-organised RAM behind an APB completer interface. Each transfer runs
// through a setup cycle followed by 1+WAIT_CYCLES access cycles. pready and
// pslverr are decoded purely from registered state, so no combinational path
// exists from the bus inputs to the response outputs.
//
// Parameters
//   DATA_WIDTH  : data bus width in bits (multiple of 8, 8..64)
//   ADDR_WIDTH  : byte-address width of paddr
//   DEPTH       : number of DATA_WIDTH-bit words (any value >= 1)
//   WAIT_CYCLES : wait states inserted per transfer (0..15)
//
// Ports
//   clock    in   bus clock, rising edge
//   resetn   in   asynchronous active-low reset
//   pselx    in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address
//   pwdata   in   write data
//   pstrb    in   write byte-lane enables
//   pready   out  transfer completes this cycle
//   prdata   out  read data (holds its value between reads)
//   pslverr  out  error response (word index out of range), only with pready
// -----------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - SHIFT;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t state, state_next;

  // Transfer context captured at the setup edge; bus changes during the
  // access phase are deliberately ignored.
  logic [3:0]            wait_cnt;
  logic [MEM_AW-1:0]     cap_idx;
  logic                  cap_write;
  logic                  cap_oor;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [STRB_W-1:0]     cap_strb;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] in_idx;
  logic             in_oor;
  logic             setup;
  logic             complete;

  // Byte-offset bits inside a word carry no information for a word RAM.
  assign in_idx = paddr[ADDR_WIDTH-1:SHIFT];
  assign in_oor = 32'(in_idx) >= 32'(DEPTH);

  if (SHIFT > 0) begin : g_low_bits
    logic unused_low_bits;
    assign unused_low_bits = ^paddr[SHIFT-1:0];
  end

  assign pready  = (state == ACCESS) && (wait_cnt == '0);
  assign pslverr = pready && cap_oor;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: state-holding processes use non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others; blocking (=) is kept
  // for the combinational process below.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and transfer strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is defaulted first so that no path
    // through the case leaves a signal unassigned, which would infer a latch.
    state_next = state;
    setup      = 1'b0;
    complete   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pselx && !penable) begin
          setup      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          // Master withdrew the select: abort without touching memory.
          state_next = IDLE;
        end else if ((wait_cnt == '0) && penable) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture registers, wait counter and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt  <= '0;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_oor   <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
      prdata    <= '0;
    end else if (setup) begin
      cap_idx   <= in_idx[MEM_AW-1:0];
      cap_write <= pwrite;
      cap_oor   <= in_oor;
      cap_wdata <= pwdata;
      cap_strb  <= pstrb;
      wait_cnt  <= 4'(WAIT_CYCLES);
      // Read data is fetched at the setup edge and simply held until pready.
      if (!pwrite) begin
        prdata <= in_oor ? '0 : mem[in_idx[MEM_AW-1:0]];
      end
    end else if ((state == ACCESS) && pselx && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array write port
  // ---------------------------------------------------------------------------
  // NOTE: the RAM has no reset so it maps onto plain storage cells; its
  // contents are undefined until written. A reset in the middle of a transfer
  // forces the FSM to IDLE, which suppresses the pending write.
  always_ff @(posedge clock) begin
    if (complete && cap_write && !cap_oor) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (cap_strb[b]) begin
          mem[cap_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
//
// Two instances share the APB bus signals except pselx: dut_a has two wait
// states, dut_b has none. A transfer-level model (word arrays plus per-cycle
// expected response) is advanced by the bus driver; a compare process checks
// both instances against it on every falling edge. Directed transfers pin the
// model with literal expectations, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        pready_a, pslverr_a, pready_b, pslverr_b;
  logic [31:0] prdata_a, prdata_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  // Model state, index 0 = dut_a (2 wait states), 1 = dut_b (0 wait states).
  logic [31:0] mmem [2][64];
  logic        exp_pready  [2];
  logic        exp_pslverr [2];
  logic [31:0] exp_prdata  [2];

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_CYCLES(2)) dut_a (
    .clock(clock), .resetn(resetn), .pselx(psel[0]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_a), .prdata(prdata_a), .pslverr(pslverr_a)
  );

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(64), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .resetn(resetn), .pselx(psel[1]), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready_b), .prdata(prdata_b), .pslverr(pslverr_b)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ready_of(input int d);
    return (d == 0) ? pready_a : pready_b;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? pslverr_a : pslverr_b;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d == 0) ? prdata_a : prdata_b;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("pready_a",  {63'd0, pready_a},  {63'd0, exp_pready[0]});
      check("pslverr_a", {63'd0, pslverr_a}, {63'd0, exp_pslverr[0]});
      check("prdata_a",  {32'd0, prdata_a},  {32'd0, exp_prdata[0]});
      check("pready_b",  {63'd0, pready_b},  {63'd0, exp_pready[1]});
      check("pslverr_b", {63'd0, pslverr_b}, {63'd0, exp_pslverr[1]});
      check("prdata_b",  {32'd0, prdata_b},  {32'd0, exp_prdata[1]});
    end
  end

  // One APB transfer on instance d, starting in the current cycle.
  // abort_k >= 0 drops pselx in access cycle S+1+abort_k.
  // Returns the observed read data/error at pready, the latency from the
  // setup cycle to pready (-1 if none) and the cycle number of pready.
  task automatic xfer(input int d, input bit wr, input logic [11:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      input int abort_k, output logic [31:0] rdata,
                      output logic err, output int lat, output int rcyc);
    int w;
    int idx;
    bit oor;
    w     = (d == 0) ? 2 : 0;
    idx   = int'(addr >> 2);
    oor   = (idx >= 64);
    lat   = -1;
    rcyc  = -1;
    rdata = '0;
    err   = 1'b0;
    // setup cycle
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata  = data; pstrb   = strb;
    exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0;
    @(posedge clock); #1;
    if (!wr) exp_prdata[d] = oor ? 32'd0 : mmem[d][idx];
    penable = 1'b1;
    for (int k = 0; k <= w; k++) begin
      if (k == abort_k) begin
        psel[d] = 1'b0;
        penable = 1'b0;
      end
      exp_pready[d]  = (k == w);
      exp_pslverr[d] = (k == w) && oor;
      // Bus contents other than select/enable must not matter now.
      paddr  = 12'($urandom);
      pwdata = $urandom;
      pwrite = 1'($urandom);
      pstrb  = 4'($urandom);
      @(negedge clock);
      if (ready_of(d)) begin
        lat   = k + 1;
        rcyc  = cyc;
        rdata = rdata_of(d);
        err   = err_of(d);
      end
      @(posedge clock); #1;
      if (k == abort_k) break;
    end
    if (abort_k < 0 && wr && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mmem[d][idx][8*b +: 8] = data[8*b +: 8];
      end
    end
    psel[d] = 1'b0; penable = 1'b0;
    exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, rc1, rc2;

    resetn = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    for (int d = 0; d < 2; d++) begin
      exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0; exp_prdata[d] = '0;
    end

    #3;
    check("reset_pready_a",  {63'd0, pready_a},  64'd0);
    check("reset_pslverr_a", {63'd0, pslverr_a}, 64'd0);
    check("reset_prdata_a",  {32'd0, prdata_a},  64'd0);
    check("reset_prdata_b",  {32'd0, prdata_b},  64'd0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    cmp_en = 1'b1;

    // Fill every word of both instances so later reads are defined.
    for (int i = 0; i < 64; i++) begin
      for (int d = 0; d < 2; d++) begin
        xfer(d, 1'b1, 12'(i * 4), $urandom, 4'hF, -1, rd, er, lat, rc1);
      end
    end

    // Write/read on the two-wait-state instance.
    xfer(0, 1'b1, 12'h004, 32'h1234_5678, 4'hF, -1, rd, er, lat, rc1);
    check("wr_lat_a", 64'(lat), 64'd3);
    check("wr_err_a", {63'd0, er}, 64'd0);
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("rd_lat_a",  64'(lat), 64'd3);
    check("rd_data_a", {32'd0, rd}, 64'h1234_5678);
    check("rd_err_a",  {63'd0, er}, 64'd0);

    // Same on the zero-wait instance.
    xfer(1, 1'b1, 12'h004, 32'h1234_5678, 4'hF, -1, rd, er, lat, rc1);
    check("wr_lat_b", 64'(lat), 64'd1);
    xfer(1, 1'b0, 12'h004, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("rd_lat_b",  64'(lat), 64'd1);
    check("rd_data_b", {32'd0, rd}, 64'h1234_5678);

    // Byte strobes: clear lanes 0 and 2 only.
    xfer(0, 1'b1, 12'h008, 32'hFFFF_FFFF, 4'b1111, -1, rd, er, lat, rc1);
    xfer(0, 1'b1, 12'h008, 32'h0000_0000, 4'b0101, -1, rd, er, lat, rc1);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("strobe_data", {32'd0, rd}, 64'hFF00_FF00);

    // Out of range: word index 64.
    xfer(0, 1'b1, 12'h000, 32'h5555_AAAA, 4'hF, -1, rd, er, lat, rc1);
    xfer(0, 1'b1, 12'h100, 32'hDEAD_BEEF, 4'hF, -1, rd, er, lat, rc1);
    check("oor_wr_lat", 64'(lat), 64'd3);
    check("oor_wr_err", {63'd0, er}, 64'd1);
    xfer(0, 1'b0, 12'h100, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("oor_rd_data", {32'd0, rd}, 64'd0);
    check("oor_rd_err",  {63'd0, er}, 64'd1);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("oor_word0", {32'd0, rd}, 64'h5555_AAAA);

    // Abort in S+1 leaves the old value.
    xfer(0, 1'b1, 12'h00C, 32'h1111_1111, 4'hF, -1, rd, er, lat, rc1);
    xfer(0, 1'b1, 12'h00C, 32'h0BAD_F00D, 4'hF, 0, rd, er, lat, rc1);
    check("abort_no_ready", 64'(lat), -64'sd1);
    xfer(0, 1'b0, 12'h00C, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("abort_data", {32'd0, rd}, 64'h1111_1111);

    // Back-to-back write then read of the same word.
    xfer(0, 1'b1, 12'h020, 32'hC0FF_EE11, 4'hF, -1, rd, er, lat, rc1);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, -1, rd, er, lat, rc2);
    check("b2b_spacing", 64'(rc2 - rc1), 64'd4);
    check("b2b_data", {32'd0, rd}, 64'hC0FF_EE11);

    // Randomized traffic, with occasional aborts and random idle gaps.
    for (int n = 0; n < 400; n++) begin
      int d, ab;
      d  = int'($urandom_range(0, 1));
      ab = (d == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : -1;
      xfer(d, 1'($urandom), 12'($urandom_range(0, 32'h13F)), $urandom,
           4'($urandom), ab, rd, er, lat, rc1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end

    // Reset in the middle of an access phase, one cycle before pready.
    xfer(0, 1'b1, 12'h018, 32'hCAFE_BABE, 4'hF, -1, rd, er, lat, rc1);
    xfer(0, 1'b0, 12'h018, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("pre_rst_data", {32'd0, rd}, 64'hCAFE_BABE);
    cmp_en  = 1'b0;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014;
    pwdata  = 32'h7777_7777; pstrb = 4'hF;
    @(posedge clock); #1 penable = 1'b1;
    @(posedge clock); #2 resetn = 1'b0;
    #1;
    check("mid_rst_pready",  {63'd0, pready_a},  64'd0);
    check("mid_rst_pslverr", {63'd0, pslverr_a}, 64'd0);
    check("mid_rst_prdata",  {32'd0, prdata_a},  64'd0);
    psel = 2'b00; penable = 1'b0;
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0; exp_prdata[d] = '0;
    end
    cmp_en = 1'b1;
    @(posedge clock); #1;
    xfer(0, 1'b1, 12'h010, 32'hA5A5_5A5A, 4'hF, -1, rd, er, lat, rc1);
    check("post_rst_wr_lat", 64'(lat), 64'd3);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, -1, rd, er, lat, rc1);
    check("post_rst_rd_data", {32'd0, rd}, 64'hA5A5_5A5A);

    repeat (2) @(posedge clock);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB memory-mapped slave: a word-organised RAM behind an APB completer interface with configurable data width, depth and wait-state count, plus byte-lane write strobes and error response. It sits on the APB bus next to the bridge/master as the generic register-file and scratch-memory target for all subsystems. It replaces the fixed 8-bit, 32-entry, two-wait-state slave with a protocol-correct, reset-clean design.

## Interface

- DATA_WIDTH, 32, data bus width in bits; multiple of 8, 8..64
- ADDR_WIDTH, 12, byte-address width of paddr
- DEPTH, 64, number of DATA_WIDTH-bit words; power of two not required
- WAIT_CYCLES, 2, wait states inserted per transfer; 0..15

- clock  input  1  bus clock, all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- pselx  input  1  slave select
- penable  input  1  access-phase indicator
- pwrite  input  1  1 = write, 0 = read
- paddr  input  ADDR_WIDTH  byte address
- pwdata  input  DATA_WIDTH  write data
- pstrb  input  DATA_WIDTH/8  write byte-lane enables
- pready  output  1  transfer completes this cycle
- prdata  output  DATA_WIDTH  read data, valid when pready=1 on a read
- pslverr  output  1  error response, valid only when pready=1

## Operation

- Word index = paddr >> log2(DATA_WIDTH/8); low address bits ignored. Index >= DEPTH is out of range.
- Reset (resetn=0, asynchronous): state IDLE, wait counter 0, pready=0, pslverr=0, prdata=0. Memory array not reset; contents undefined until written.
- States: IDLE, ACCESS.
- IDLE: when pselx=1 and penable=0 (setup cycle), capture word index, pwrite, pwdata, pstrb and range flag; load counter with WAIT_CYCLES; go ACCESS. For in-range reads, prdata <= mem[index] at that edge; out-of-range reads set prdata <= 0.
- ACCESS: pready = (counter==0); pslverr = pready & range flag set. Both decoded from registers only, with no combinational path from bus inputs.
  - counter != 0 and pselx=1: decrement the counter.
  - counter == 0, pselx=1, penable=1: completion edge. For in-range writes, update each byte lane i where pstrb[i]=1 from captured pwdata. Return to IDLE.
  - pselx=0 at any edge in ACCESS: abort. Return to IDLE with no memory write; prdata keeps its value.
- Out-of-range writes never modify memory. pstrb=0 writes complete normally (OKAY) with no change.
- prdata holds its last value between reads; it changes only at a read setup edge or on reset.
- Back-to-back transfers: IDLE at the completion edge, so a setup cycle in the very next cycle is accepted. No idle gap is required.
- Master-side changes to paddr, pwrite or pwdata during ACCESS are ignored; the captured values are used.

## Timing

- Cycle S = setup (pselx=1, penable=0); access cycles follow from S+1.
- pready=1 in cycle S+1+WAIT_CYCLES, exactly one cycle per transfer; total transfer length 2+WAIT_CYCLES cycles.
- WAIT_CYCLES=0: pready=1 in S+1, giving a zero-wait transfer.
- Write data is visible to a read whose setup cycle is at or after the cycle following the completion edge.
- Reset asserted mid-transfer: outputs take their reset values immediately (asynchronously) and the pending write is dropped. The first transfer after deassertion must begin with a fresh setup cycle.
- pslverr=0 whenever pready=0.

## Test plan

- Reset: drive resetn=0 mid-ACCESS with pready about to assert -> pready=0, pslverr=0, prdata=0 immediately; after release, write 0xA5A5_5A5A to addr 0x010 completes with pready in S+3 (WAIT_CYCLES=2).
- Write/read: write 0x1234_5678 to addr 0x004, then read addr 0x004 -> pready in S+3, prdata=0x1234_5678, pslverr=0. Repeat on a WAIT_CYCLES=0 instance -> pready in S+1.
- Byte strobes: write 0xFFFF_FFFF with pstrb=4'b1111 to 0x008, then 0x0000_0000 with pstrb=4'b0101 -> read returns 0xFF00_FF00.
- Out of range (DEPTH=64): write 0xDEAD_BEEF to addr 0x100 -> pready in S+3 with pslverr=1; read 0x100 -> prdata=0, pslverr=1; word 0 unchanged.
- Abort: start write of 0x0BAD_F00D to 0x00C over old value 0x1111_1111, drop pselx in S+1 -> returns to IDLE, no pready; read 0x00C -> 0x1111_1111.
- Back-to-back: write to 0x020 immediately followed by a setup cycle for a read of 0x020 -> second pready 4 cycles after the first, prdata equals the written data.
